// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with load handshake, bit counter and frame/done flags.
// Optional build macro PISO_PARITY_EN appends a parity bit after the data bits.
//
// state        | meaning
// ST_IDLE      | line at IDLE_LEVEL, waiting for a word
// ST_SHIFT     | data bit presented, advancing on each sh_ena
// ST_PARITY    | parity bit presented (PISO_PARITY_EN builds only)
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    input  logic             sh_ena,
    output logic             data_out,
    output logic             frame,
    output logic             done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32 || PARITY_ODD > 1'b1) begin : g_bad_param
        $error("piso_serializer: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_last_bit;
    logic             w_word_end;
    logic             w_accept;
    logic             w_out_bit;

    always_comb begin
        w_last_bit  = (r_state == ST_SHIFT) && sh_ena && (r_cnt == LAST);
`ifdef PISO_PARITY_EN
        w_word_end  = (r_state == ST_PARITY) && sh_ena;
`else
        w_word_end  = w_last_bit;
`endif
        load_ready  = (r_state == ST_IDLE) || w_word_end;
        w_accept    = load_valid && load_ready;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
`ifdef PISO_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
            ST_PARITY: begin
                if (sh_ena) w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Vacated positions take IDLE_LEVEL so the line settles there once the word drains.
    always_comb begin
        if (MSB_FIRST) w_shifted = {r_shreg[WIDTH-2:0], IDLE_LEVEL};
        else           w_shifted = {IDLE_LEVEL, r_shreg[WIDTH-1:1]};
        w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_shreg <= {WIDTH{IDLE_LEVEL}};
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_word_end;
            if (w_accept) begin
                r_shreg <= data_in;
                r_cnt   <= '0;
            end else if ((r_state == ST_SHIFT) && sh_ena) begin
                r_shreg <= w_shifted;
                r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            end
        end
    end

`ifdef PISO_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)        r_parity <= 1'b0;
        else if (w_accept) r_parity <= (^data_in) ^ PARITY_ODD;
    end

    assign data_out = (r_state == ST_PARITY) ? r_parity : w_out_bit;
`else
    assign data_out = w_out_bit;
`endif

    assign frame = (r_state != ST_IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an LSB-first and an MSB-first instance share stimulus;
// expected bits are queued when a word is accepted and compared while the word is on the line.
module tb_piso_serializer;

    localparam int W = 8;
    localparam bit PAR_ODD = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         sh_ena = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         load_ready, data_out, frame, done;
    logic         load_ready_m, data_out_m, frame_m, done_m;

    int n_tests = 0;
    int n_fail  = 0;
    bit q_l[$];
    bit q_m[$];
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .PARITY_ODD(PAR_ODD)) dut (
        .clk(clk), .clr_n(clr_n), .load_valid(load_valid), .data_in(data_in),
        .load_ready(load_ready), .sh_ena(sh_ena), .data_out(data_out), .frame(frame), .done(done)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .PARITY_ODD(PAR_ODD)) dut_msb (
        .clk(clk), .clr_n(clr_n), .load_valid(load_valid), .data_in(data_in),
        .load_ready(load_ready_m), .sh_ena(sh_ena), .data_out(data_out_m), .frame(frame_m), .done(done_m)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q_l.push_back(d[i]);
            q_m.push_back(d[W-1-i]);
        end
`ifdef PISO_PARITY_EN
        q_l.push_back((^d) ^ PAR_ODD);
        q_m.push_back((^d) ^ PAR_ODD);
`endif
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the reference model.
    task automatic cycle(input bit lv, input logic [W-1:0] d, input bit sh);
        bit exp_ready, acc, end_w;
        load_valid = lv;
        data_in    = d;
        sh_ena     = sh;
        @(negedge clk);
        exp_ready = !m_busy || ((m_cnt == NB - 1) && sh);
        check_eq("load_ready", {31'd0, load_ready}, {31'd0, exp_ready});
        check_eq("frame", {31'd0, frame}, {31'd0, m_busy});
        check_eq("done", {31'd0, done}, {31'd0, m_done});
        check_eq("frame_msb", {31'd0, frame_m}, {31'd0, m_busy});
        check_eq("done_msb", {31'd0, done_m}, {31'd0, m_done});
        if (m_busy && q_l.size() > 0) begin
            check_eq("bit_lsb", {31'd0, data_out}, {31'd0, q_l[0]});
            check_eq("bit_msb", {31'd0, data_out_m}, {31'd0, q_m[0]});
        end else begin
            check_eq("idle_lsb", {31'd0, data_out}, 32'd0);
            check_eq("idle_msb", {31'd0, data_out_m}, 32'd0);
        end
        end_w = m_busy && sh && (m_cnt == NB - 1);
        if (m_busy && sh) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
            m_cnt++;
            if (end_w) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end
        end
        acc = lv && exp_ready;
        if (acc) begin
            push_word(d);
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        m_done = end_w;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        clr_n      = 1'b0;
        load_valid = 1'b1;
        sh_ena     = 1'b1;
        data_in    = '1;
        repeat (n) begin
            @(negedge clk);
            check_eq("rst_data", {31'd0, data_out}, 32'd0);
            check_eq("rst_data_msb", {31'd0, data_out_m}, 32'd0);
            check_eq("rst_frame", {31'd0, frame}, 32'd0);
            check_eq("rst_done", {31'd0, done}, 32'd0);
            check_eq("rst_ready", {31'd0, load_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        q_l.delete();
        q_m.delete();
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_cnt      = 0;
        clr_n      = 1'b1;
        load_valid = 1'b0;
        sh_ena     = 1'b0;
    endtask

    initial begin
        apply_reset(3);

        // C1 with a strobe every cycle
        cycle(1'b1, 8'hC1, 1'b0);
        repeat (NB + 3) cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0);

        // slow strobe, FF offered mid-frame and held
        cycle(1'b1, 8'hC1, 1'b0);
        for (int i = 0; i < 3 * NB + 6; i++)
            cycle(i >= 4, 8'hFF, (i % 3) == 2);
        repeat (NB + 3) cycle(1'b0, '0, 1'b1);

        // back-to-back words with load_valid held high
        cycle(1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < NB; i++) cycle(1'b1, 8'hF0, 1'b1);
        repeat (NB + 3) cycle(1'b0, '0, 1'b1);

        // reset abort mid-word, then a fresh word
        cycle(1'b1, 8'hA5, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        apply_reset(1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1);
        repeat (NB + 3) cycle(1'b0, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (NB + 3) cycle(1'b0, '0, 1'b1);
        check_eq("sb_drain", q_l.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
